// File: rtl/fetch_unit.sv
// fetch_unit: instruction supplier for a single-cycle LEGv8 datapath.
// Owns the PC, fetches 32-bit words over a req/ack imem port, holds each
// word for the datapath until it retires, and resolves B, B.cond and CBZ.
// Optional feature: define FETCH_PERF_EN to add saturating retire/taken
// performance counters (perf_retired, perf_taken).
module fetch_unit #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_data,
  output logic [31:0]     instruction,
  output logic            instr_valid,
  input  logic            stall,
  input  logic            zero,
  input  logic [3:0]      frOut,
  output logic            retire,
  output logic [PC_W-1:0] pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_retired,
  output logic [31:0]     perf_taken
`endif
);

  typedef enum logic [0:0] {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  // Reset PC with its byte-offset bits cleared so pc stays word aligned.
  localparam logic [PC_W-1:0] RESET_PC_ALIGNED = {RESET_PC[PC_W-1:2], 2'b00};
  localparam logic [PC_W-1:0] PC_STEP          = {{(PC_W-3){1'b0}}, 3'b100};

  state_t          state_r;
  logic [PC_W-1:0] pc_plus4_s;
  logic [PC_W-1:0] off26_s;
  logic [PC_W-1:0] off19_s;
  logic [PC_W-1:0] next_pc_s;
  logic            is_b_s;
  logic            is_bcond_s;
  logic            is_cbz_s;
  logic            taken_s;
  logic            unused_carry_s;

  // B.cond evaluation on {V,N,Z}; unsupported codes are never taken.
  function automatic logic cond_holds(input logic [3:0] code, input logic [2:0] vnz);
    logic v;
    logic n;
    logic z;
    v = vnz[2];
    n = vnz[1];
    z = vnz[0];
    case (code)
      4'b0000: cond_holds = z;
      4'b0001: cond_holds = ~z;
      4'b1010: cond_holds = (n == v);
      4'b1011: cond_holds = (n != v);
      4'b1100: cond_holds = ~z & (n == v);
      4'b1101: cond_holds = z | (n != v);
      default: cond_holds = 1'b0;
    endcase
  endfunction

  // Carry flag plays no part in the supported branch conditions.
  assign unused_carry_s = frOut[0];

  // Port-facing decodes of the registered state; request drops while reset is held.
  assign imem_req  = (state_r == S_REQ) & ~reset;
  assign imem_addr = pc;
  assign retire    = instr_valid & ~stall;

  // Branch decode and next-PC selection from the held instruction; flags are
  // only consumed when the instruction actually retires.
  always_comb begin
    pc_plus4_s = pc + PC_STEP;
    off26_s    = {{(PC_W-28){instruction[25]}}, instruction[25:0], 2'b00};
    off19_s    = {{(PC_W-21){instruction[23]}}, instruction[23:5], 2'b00};
    is_b_s     = (instruction[31:26] == 6'b000101);
    is_bcond_s = (instruction[31:24] == 8'b01010100);
    is_cbz_s   = (instruction[31:24] == 8'b10110100);
    taken_s    = 1'b0;
    next_pc_s  = pc_plus4_s;
    if (is_b_s) begin
      taken_s   = 1'b1;
      next_pc_s = pc + off26_s;
    end else if (is_bcond_s) begin
      taken_s   = cond_holds(instruction[3:0], frOut[3:1]);
      next_pc_s = taken_s ? (pc + off19_s) : pc_plus4_s;
    end else if (is_cbz_s) begin
      taken_s   = zero;
      next_pc_s = taken_s ? (pc + off19_s) : pc_plus4_s;
    end else begin
      taken_s   = 1'b0;
      next_pc_s = pc_plus4_s;
    end
  end

  // Fetch FSM: REQ waits for the imem ack, HOLD presents the word until it retires.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_REQ;
      pc          <= RESET_PC_ALIGNED;
      instruction <= 32'h0000_0000;
      instr_valid <= 1'b0;
    end else begin
      case (state_r)
        S_REQ: begin
          if (imem_ack) begin
            instruction <= imem_data;
            instr_valid <= 1'b1;
            state_r     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            pc          <= next_pc_s;
            instr_valid <= 1'b0;
            state_r     <= S_REQ;
          end
        end
        default: begin
          instr_valid <= 1'b0;
          state_r     <= S_REQ;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating counters of retired instructions and of retires that left the sequential path.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_retired <= 32'h0000_0000;
      perf_taken   <= 32'h0000_0000;
    end else if (retire) begin
      if (perf_retired != 32'hFFFF_FFFF) begin
        perf_retired <= perf_retired + 32'd1;
      end
      if ((next_pc_s != pc_plus4_s) && (perf_taken != 32'hFFFF_FFFF)) begin
        perf_taken <= perf_taken + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven directed bench for fetch_unit (PC_W=64, RESET_PC=0).
// Each table row is one fetch/hold/retire round trip; the rows chain so that
// every expected next address is the following row's fetch address.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        stall;
  logic        zero;
  logic [3:0]  frOut;
  logic        retire;
  logic [63:0] pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_retired;
  logic [31:0] perf_taken;
`endif

  int checks;
  int errors;

  fetch_unit #(.PC_W(64), .RESET_PC(64'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .stall       (stall),
    .zero        (zero),
    .frOut       (frOut),
    .retire      (retire),
    .pc          (pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_retired(perf_retired),
    .perf_taken  (perf_taken)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] word;
    logic        z;
    logic [3:0]  fr;
    int          stall_n;
    int          lat;
    logic [63:0] next;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    // fetch phase
    chk("req_in_REQ", {63'd0, imem_req}, 64'd1);
    chk("imem_addr", imem_addr, v.addr);
    for (int i = 0; i < v.lat; i++) begin
      imem_ack = 1'b0;
      tick();
      chk("req_held", {63'd0, imem_req}, 64'd1);
      chk("valid_low_waiting", {63'd0, instr_valid}, 64'd0);
    end
    imem_ack  = 1'b1;
    imem_data = v.word;
    tick();
    imem_ack  = 1'b0;
    imem_data = 32'h0;
    chk("valid_in_HOLD", {63'd0, instr_valid}, 64'd1);
    chk("instruction", {32'd0, instruction}, {32'd0, v.word});
    chk("req_low_HOLD", {63'd0, imem_req}, 64'd0);
    // stall phase: opposite branch inputs and a stray ack must not matter
    for (int i = 0; i < v.stall_n; i++) begin
      stall     = 1'b1;
      zero      = ~v.z;
      frOut     = ~v.fr;
      imem_ack  = 1'b1;
      imem_data = 32'hDEAD_BEEF;
      #1;
      chk("no_retire_stall", {63'd0, retire}, 64'd0);
      tick();
      chk("instr_frozen", {32'd0, instruction}, {32'd0, v.word});
      chk("pc_frozen", pc, v.addr);
      chk("req_low_stall", {63'd0, imem_req}, 64'd0);
    end
    // retire cycle
    stall     = 1'b0;
    imem_ack  = 1'b0;
    imem_data = 32'h0;
    zero      = v.z;
    frOut     = v.fr;
    #1;
    chk("retire_pulse", {63'd0, retire}, 64'd1);
    tick();
    chk("next_pc", imem_addr, v.next);
    chk("valid_low_after", {63'd0, instr_valid}, 64'd0);
    chk("retire_low_after", {63'd0, retire}, 64'd0);
  endtask

  localparam logic [31:0] ADD = 32'h8B02_0020;

  int exp_retired;
  int exp_taken;

  initial begin
    checks      = 0;
    errors      = 0;
    exp_retired = 0;
    exp_taken   = 0;

    //           addr                      word          z     fr       st lat next
    vecs[0]  = '{64'h0,                  ADD,          1'b0, 4'b0000, 0, 1, 64'h4};
    vecs[1]  = '{64'h4,                  ADD,          1'b0, 4'b0000, 5, 0, 64'h8};
    vecs[2]  = '{64'h8,                  ADD,          1'b0, 4'b0000, 0, 1, 64'hC};
    vecs[3]  = '{64'hC,                  32'h1400_003D, 1'b0, 4'b0000, 0, 0, 64'h100};
    vecs[4]  = '{64'h100,                32'h17FF_FFFE, 1'b0, 4'b0000, 0, 2, 64'hF8};
    vecs[5]  = '{64'hF8,                 32'h17FF_FFD2, 1'b0, 4'b0000, 0, 0, 64'h40};
    vecs[6]  = '{64'h40,                 32'h5400_008B, 1'b0, 4'b1000, 2, 1, 64'h50};
    vecs[7]  = '{64'h50,                 32'h17FF_FFFC, 1'b0, 4'b0000, 0, 0, 64'h40};
    vecs[8]  = '{64'h40,                 32'h5400_008B, 1'b0, 4'b0000, 2, 0, 64'h44};
    vecs[9]  = '{64'h44,                 32'h5400_008F, 1'b0, 4'b1000, 0, 1, 64'h48};
    vecs[10] = '{64'h48,                 32'h5400_0040, 1'b0, 4'b0010, 1, 0, 64'h50};
    vecs[11] = '{64'h50,                 32'h5400_0041, 1'b0, 4'b0010, 1, 0, 64'h54};
    vecs[12] = '{64'h54,                 32'h5400_004C, 1'b0, 4'b0000, 1, 0, 64'h5C};
    vecs[13] = '{64'h5C,                 32'h5400_004D, 1'b0, 4'b0000, 1, 0, 64'h60};
    vecs[14] = '{64'h60,                 32'h5400_004A, 1'b0, 4'b0100, 1, 0, 64'h64};
    vecs[15] = '{64'h64,                 32'h17FF_FFEF, 1'b0, 4'b0000, 0, 0, 64'h20};
    vecs[16] = '{64'h20,                 32'hB400_0100, 1'b1, 4'b0000, 3, 1, 64'h40};
    vecs[17] = '{64'h40,                 32'h17FF_FFF8, 1'b0, 4'b0000, 0, 0, 64'h20};
    vecs[18] = '{64'h20,                 32'hB400_0100, 1'b0, 4'b0000, 3, 0, 64'h24};
    vecs[19] = '{64'h24,                 32'h1400_0000, 1'b0, 4'b0000, 0, 0, 64'h24};
    vecs[20] = '{64'h24,                 32'h17FF_FFF7, 1'b0, 4'b0000, 0, 0, 64'h0};
    vecs[21] = '{64'h0,                  32'h17FF_FFFF, 1'b0, 4'b0000, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[22] = '{64'hFFFF_FFFF_FFFF_FFFC, ADD,         1'b0, 4'b0000, 0, 0, 64'h0};

    reset     = 1'b1;
    imem_ack  = 1'b0;
    imem_data = 32'h0;
    stall     = 1'b0;
    zero      = 1'b0;
    frOut     = 4'b0000;
    tick();
    tick();
    chk("rst_req", {63'd0, imem_req}, 64'd0);
    chk("rst_valid", {63'd0, instr_valid}, 64'd0);
    chk("rst_instruction", {32'd0, instruction}, 64'd0);
    chk("rst_retire", {63'd0, retire}, 64'd0);
    chk("rst_pc", pc, 64'h0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_retired", {32'd0, perf_retired}, 64'd0);
    chk("rst_perf_taken", {32'd0, perf_taken}, 64'd0);
`endif
    reset = 1'b0;
    #1;
    chk("req_first_cycle", {63'd0, imem_req}, 64'd1);

    for (int k = 0; k < NV; k++) begin
      run_vec(vecs[k]);
      exp_retired++;
      if (vecs[k].next != vecs[k].addr + 64'd4) exp_taken++;
    end

`ifdef FETCH_PERF_EN
    chk("perf_retired", {32'd0, perf_retired}, exp_retired);
    chk("perf_taken", {32'd0, perf_taken}, exp_taken);
`endif

    // Reset while a request is outstanding; the ack lands during reset.
    imem_data = 32'h1111_2222;
    reset     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      imem_ack = (i == 2);
      tick();
      chk("rst_mid_req", {63'd0, imem_req}, 64'd0);
      chk("rst_mid_valid", {63'd0, instr_valid}, 64'd0);
    end
    imem_ack  = 1'b0;
    imem_data = 32'h0;
    reset     = 1'b0;
    #1;
    chk("post_rst_addr", imem_addr, 64'h0);
    chk("post_rst_req", {63'd0, imem_req}, 64'd1);
`ifdef FETCH_PERF_EN
    chk("post_rst_perf_retired", {32'd0, perf_retired}, 64'd0);
    chk("post_rst_perf_taken", {32'd0, perf_taken}, 64'd0);
`endif
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("late_ack_ignored", {63'd0, instr_valid}, 64'd0);
      chk("late_ack_instr", {32'd0, instruction}, 64'd0);
    end
    run_vec('{64'h0, ADD, 1'b0, 4'b0000, 0, 0, 64'h4});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
